wtm_mult: RTL and testbench



---
 rtl/wtm_pkg.sv | 5 +
 rtl/wtm_mult_if.sv | 12 +
 rtl/wtm_fa.sv | 11 +
 rtl/wtm_mult.sv | 101 ++++++++++
 tb/tb_wtm_mult.sv | 137 +++++++++++++
 5 files changed

// File: rtl/wtm_pkg.sv
// Shared width constants for the 5x5 Wallace-tree multiplier.
package wtm_pkg;
    localparam int unsigned WTM_OP_W   = 5;
    localparam int unsigned WTM_PROD_W = 10;
endpackage

// File: rtl/wtm_mult_if.sv
// Operand/product bundle for wtm_mult; master drives operands, slave returns product.
interface wtm_mult_if
    import wtm_pkg::*;
();
    logic [WTM_OP_W-1:0]   in1;
    logic [WTM_OP_W-1:0]   in2;
    logic [WTM_PROD_W-1:0] result;
    logic                  cout;

    modport master (output in1, output in2, input result, input cout);
    modport slave  (input in1, input in2, output result, output cout);
endinterface

// File: rtl/wtm_fa.sv
// 1-bit full adder; used as a half adder with i_cin tied low.
module wtm_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_cin;
    assign o_co = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/wtm_mult.sv
// Unsigned 5x5 Wallace-tree multiplier, registered product and carry-out.
// Define WTM_PIPE_EN to register the two reduced rows (latency 2 instead of 1).
module wtm_mult
    import wtm_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    wtm_mult_if.slave  bus
);
    localparam int unsigned W = WTM_PROD_W;

    logic [W-1:0] w_row [WTM_OP_W];
    logic [W-1:0] w_la  [3];
    logic [W-1:0] w_lb  [3];
    logic [W-1:0] w_lc  [3];
    logic [W-1:0] w_sum [3];
    logic [W-1:0] w_co  [3];
    logic [W-1:0] w_fin_a;
    logic [W-1:0] w_fin_b;
    logic [W-1:0] w_rca_s;
    logic [W:0]   w_rca_c;
    logic         w_unused_co;
    logic [W-1:0] r_result;
    logic         r_cout;

    // Row i holds pp[i][j] = in1[j] & in2[i] at weight i+j.
    for (genvar i = 0; i < WTM_OP_W; i++) begin : g_pp
        assign w_row[i] = W'({{WTM_OP_W{bus.in2[i]}} & bus.in1}) << i;
    end

    // Three carry-save layers: 5 rows -> 4 -> 3 -> 2.
    assign w_la[0] = w_row[0];
    assign w_lb[0] = w_row[1];
    assign w_lc[0] = w_row[2];
    assign w_la[1] = w_sum[0];
    assign w_lb[1] = {w_co[0][W-2:0], 1'b0};
    assign w_lc[1] = w_row[3];
    assign w_la[2] = w_sum[1];
    assign w_lb[2] = {w_co[1][W-2:0], 1'b0};
    assign w_lc[2] = w_row[4];

    for (genvar l = 0; l < 3; l++) begin : g_layer
        for (genvar k = 0; k < W; k++) begin : g_col
            wtm_fa u_fa (
                .i_a   (w_la[l][k]),
                .i_b   (w_lb[l][k]),
                .i_cin (w_lc[l][k]),
                .o_s   (w_sum[l][k]),
                .o_co  (w_co[l][k])
            );
        end
    end

    // Top-column carries of the tree cannot be set since 31*31 < 1024.
    assign w_unused_co = w_co[0][W-1] ^ w_co[1][W-1] ^ w_co[2][W-1];

`ifdef WTM_PIPE_EN
    logic [W-1:0] r_row_a;
    logic [W-1:0] r_row_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_row_a <= '0;
            r_row_b <= '0;
        end else begin
            r_row_a <= w_sum[2];
            r_row_b <= {w_co[2][W-2:0], 1'b0};
        end
    end

    assign w_fin_a = r_row_a;
    assign w_fin_b = r_row_b;
`else
    assign w_fin_a = w_sum[2];
    assign w_fin_b = {w_co[2][W-2:0], 1'b0};
`endif

    assign w_rca_c[0] = 1'b0;
    for (genvar k = 0; k < W; k++) begin : g_rca
        wtm_fa u_fa (
            .i_a   (w_fin_a[k]),
            .i_b   (w_fin_b[k]),
            .i_cin (w_rca_c[k]),
            .o_s   (w_rca_s[k]),
            .o_co  (w_rca_c[k+1])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_result <= w_rca_s;
            r_cout   <= w_rca_c[W];
        end
    end

    assign bus.result = r_result;
    assign bus.cout   = r_cout;
endmodule

// File: tb/tb_wtm_mult.sv
// Directed-vector and exhaustive bench for wtm_mult.
module tb_wtm_mult;
    import wtm_pkg::*;

`ifdef WTM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] res;
        logic       co;
    } vec_t;

    logic clock;
    logic resetn;
    int   n_pass;
    int   n_total;
    vec_t vecs [10];

    wtm_mult_if bus ();

    wtm_mult dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {cout,result}=%h expected %h", name, act, exp);
    endtask

    task automatic apply(input logic [4:0] a, input logic [4:0] b);
        @(negedge clock);
        bus.in1 = a;
        bus.in2 = b;
        repeat (LAT) @(negedge clock);
    endtask

    initial begin
        logic [10:0] exp;
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{5'b10010, 5'b00010, 10'd36,  1'b0};
        vecs[1] = '{5'b10010, 5'b00011, 10'd54,  1'b0};
        vecs[2] = '{5'd0,     5'd31,    10'd0,   1'b0};
        vecs[3] = '{5'd1,     5'd31,    10'd31,  1'b0};
        vecs[4] = '{5'd31,    5'd31,    10'd961, 1'b0};
        vecs[5] = '{5'd21,    5'd10,    10'd210, 1'b0};
        vecs[6] = '{5'd31,    5'd1,     10'd31,  1'b0};
        vecs[7] = '{5'd16,    5'd16,    10'd256, 1'b0};
        vecs[8] = '{5'd7,     5'd9,     10'd63,  1'b0};
        vecs[9] = '{5'd0,     5'd0,     10'd0,   1'b0};

        // Reset held with max operands: outputs stay clear across edges.
        resetn  = 1'b0;
        bus.in1 = 5'h1F;
        bus.in2 = 5'h1F;
        #1;
        check("reset_async", {bus.cout, bus.result}, 11'h000);
        repeat (3) @(negedge clock);
        check("reset_hold", {bus.cout, bus.result}, 11'h000);
        resetn = 1'b1;
        repeat (LAT) @(negedge clock);
        check("reset_release", {bus.cout, bus.result}, {1'b0, 10'h3C1});

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b),
                  {bus.cout, bus.result}, {vecs[i].co, vecs[i].res});
        end

        // Back-to-back: 0*31 then 1*31 on consecutive edges.
        @(negedge clock);
        bus.in1 = 5'd0;
        bus.in2 = 5'd31;
        @(negedge clock);
        bus.in1 = 5'd1;
        repeat (LAT - 1) @(negedge clock);
        check("b2b_first", {bus.cout, bus.result}, 11'd0);
        @(negedge clock);
        check("b2b_second", {bus.cout, bus.result}, 11'd31);

        // Exhaustive sweep at full throughput.
        begin
            int errs;
            int hist [$];
            errs = 0;
            for (int idx = 0; idx < 1024 + LAT; idx++) begin
                @(negedge clock);
                if (idx >= LAT) begin
                    exp = 11'(hist.pop_front());
                    if ({bus.cout, bus.result} !== exp) begin
                        errs++;
                        if (errs <= 5)
                            $display("FAIL sweep_%0d: got %h expected %h", idx - LAT,
                                     {bus.cout, bus.result}, exp);
                    end
                end
                if (idx < 1024) begin
                    bus.in1 = idx[4:0];
                    bus.in2 = idx[9:5];
                    hist.push_back(int'(idx[4:0]) * int'(idx[9:5]));
                end
            end
            n_total++;
            if (errs == 0) n_pass++;
            else $display("FAIL sweep_total: got %0d errors expected 0", errs);
        end

        // Asynchronous reset between edges clears outputs without a clock.
        apply(5'd27, 5'd19);
        check("pre_areset", {bus.cout, bus.result}, 11'd513);
        #2;
        resetn = 1'b0;
        #1;
        check("areset_clear", {bus.cout, bus.result}, 11'd0);
        @(negedge clock);
        check("areset_hold", {bus.cout, bus.result}, 11'd0);
        bus.in1 = 5'd13;
        bus.in2 = 5'd29;
        resetn  = 1'b1;
        repeat (LAT) @(negedge clock);
        check("areset_release", {bus.cout, bus.result}, 11'd377);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
